// File: rtl/door_access_sequencer_if.sv
// Keypad/actuator bundle for door_access_sequencer.
// The keypad side (master) drives digits and strobes; the sequencer (slave)
// returns the door, alarm and debug status.
interface door_access_sequencer_if #(
  parameter int DW = 4,
  parameter int CW = 2
) ();
  logic          digit_valid;
  logic [DW-1:0] digit;
  logic          clear;
  logic          enter;
  logic          chg_req;
  logic          unlock;
  logic          alarm;
  logic          locked_out;
  logic [CW-1:0] cnt;
  logic [2:0]    state;
  logic          busy;

  modport master (
    output digit_valid, digit, clear, enter, chg_req,
    input  unlock, alarm, locked_out, cnt, state, busy
  );

  modport slave (
    input  digit_valid, digit, clear, enter, chg_req,
    output unlock, alarm, locked_out, cnt, state, busy
  );
endinterface

// File: rtl/door_access_sequencer.sv
// Keypad-side door access controller: collects password digits, checks them
// against the stored password, counts failures, drives a timed unlock pulse,
// enforces a timed alarm lockout and lets the password be changed while open.
// Optional feature: define DIGIT_TIMEOUT_EN to abort an entry after
// TIMEOUT_CYC idle cycles between digits (counted as a failure in ENTRY).
module door_access_sequencer #(
  parameter int                   DIGITS      = 3,
  parameter int                   DW          = 4,
  parameter int                   MAX_TRIES   = 3,
  parameter int                   UNLOCK_CYC  = 16,
  parameter int                   LOCK_CYC    = 64,
  parameter logic [DIGITS*DW-1:0] DEFAULT_PWD = 12'h123,
  parameter int                   TIMEOUT_CYC = 32
) (
  input logic                    clk,
  input logic                    rstn,
  door_access_sequencer_if.slave bus
);

  localparam int PW     = DIGITS * DW;
  localparam int CW     = $clog2(MAX_TRIES + 1);
  localparam int DCW    = $clog2(DIGITS + 1);
  // One down-counter serves unlock, lockout and the inter-digit timeout,
  // since those phases never overlap; size it for the longest of them.
  localparam int TMAX_A = (UNLOCK_CYC > LOCK_CYC) ? UNLOCK_CYC : LOCK_CYC;
  localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [DCW-1:0] DIGITS_C  = DCW'(DIGITS);
  localparam logic [CW-1:0]  MAX_C     = CW'(MAX_TRIES);
  localparam logic [CW-1:0]  LAST_TRY  = CW'(MAX_TRIES - 1);
  localparam logic [TW-1:0]  UNLOCK_T  = TW'(UNLOCK_CYC);
  localparam logic [TW-1:0]  LOCK_T    = TW'(LOCK_CYC);
  localparam logic [TW-1:0]  TIMER_ONE = TW'(1);
`ifdef DIGIT_TIMEOUT_EN
  localparam logic [TW-1:0]  TIMEOUT_T = TW'(TIMEOUT_CYC);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_CHG     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   entry_q, entry_d;
  logic [DCW-1:0]  dcount_q, dcount_d;
  logic [PW-1:0]   pwd_q, pwd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   shifted;
  logic            digit_ok;

  assign shifted  = (entry_q << DW) | PW'(bus.digit);
  assign digit_ok = bus.digit_valid && (dcount_q < DIGITS_C);

  // Register all controller state; reset restores the factory password too.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      entry_q  <= '0;
      dcount_q <= '0;
      pwd_q    <= DEFAULT_PWD;
      cnt_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      dcount_q <= dcount_d;
      pwd_q    <= pwd_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state logic; within a state clear beats enter beats digit_valid.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    dcount_d = dcount_q;
    pwd_d    = pwd_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          entry_d  = '0;
          dcount_d = '0;
        end else if (bus.enter) begin
          state_d = S_FAIL;
        end else if (bus.digit_valid) begin
          entry_d  = shifted;
          dcount_d = DCW'(1);
          state_d  = S_ENTRY;
`ifdef DIGIT_TIMEOUT_EN
          timer_d  = TIMEOUT_T;
`endif
        end
      end
      S_ENTRY, S_CHG: begin
        if (bus.clear) begin
          entry_d  = '0;
          dcount_d = '0;
          state_d  = S_IDLE;
        end else if (bus.enter) begin
          if (state_q == S_ENTRY) begin
            state_d = S_CHECK;
          end else begin
            if (dcount_q == DIGITS_C) begin
              pwd_d = entry_q;
            end
            entry_d  = '0;
            dcount_d = '0;
            state_d  = S_IDLE;
          end
        end else if (digit_ok) begin
          entry_d  = shifted;
          dcount_d = dcount_q + 1'b1;
`ifdef DIGIT_TIMEOUT_EN
          timer_d  = TIMEOUT_T;
`endif
        end
`ifdef DIGIT_TIMEOUT_EN
        else if (timer_q == TIMER_ONE) begin
          entry_d  = '0;
          dcount_d = '0;
          state_d  = (state_q == S_ENTRY) ? S_FAIL : S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      S_CHECK: begin
        entry_d  = '0;
        dcount_d = '0;
        if ((dcount_q == DIGITS_C) && (entry_q == pwd_q)) begin
          state_d = S_OPEN;
          cnt_d   = '0;
          timer_d = UNLOCK_T;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_OPEN: begin
        if (bus.chg_req) begin
          state_d = S_CHG;
`ifdef DIGIT_TIMEOUT_EN
          timer_d = TIMEOUT_T;
`endif
        end else begin
          timer_d = timer_q - 1'b1;
          if (timer_q == TIMER_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        if (cnt_q != MAX_C) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == LAST_TRY) begin
          state_d = S_LOCKOUT;
          timer_d = LOCK_T;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == TIMER_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.unlock     = (state_q == S_OPEN);
  assign bus.alarm      = (state_q == S_LOCKOUT);
  assign bus.locked_out = (state_q == S_LOCKOUT);
  assign bus.cnt        = cnt_q;
  assign bus.state      = state_q;
  assign bus.busy       = (state_q == S_CHECK) || (state_q == S_OPEN) ||
                          (state_q == S_LOCKOUT) || (state_q == S_CHG);

endmodule
